// File: rtl/rv32_pipeline_pkg.sv
// Shared RV32 pipeline types and constants.
//   reg_addr_t     : 5-bit architectural register index
//   forward_sel_t  : operand forwarding source select
//   NOP_INSTR      : canonical NOP (addi x0, x0, 0)
//   RESET_PC       : fetch address after reset
package rv32_pipeline_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } forward_sel_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/fwd_mux.sv
// 3:1 operand select for the ID/EX capture path.
//   sel_i       : forwarding source
//   rf_data_i   : register-file read data (default path)
//   mem_data_i  : EX/MEM result
//   wb_data_i   : WB result
//   data_o      : selected operand
module fwd_mux
  import rv32_pipeline_pkg::*;
(
  input  forward_sel_t sel_i,
  input  logic [31:0]  rf_data_i,
  input  logic [31:0]  mem_data_i,
  input  logic [31:0]  wb_data_i,
  output logic [31:0]  data_o
);

  // The unused encoding falls back to register-file data.
  always_comb begin
    data_o = rf_data_i;
    case (sel_i)
      FWD_MEM: data_o = mem_data_i;
      FWD_WB:  data_o = wb_data_i;
      default: data_o = rf_data_i;
    endcase
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// PC, IF/ID and ID/EX pipeline registers with stall/bubble control,
// operand forwarding at ID/EX capture and saturating hazard counters.
//   clk, rst_n            : clock, synchronous active-low reset
//   branch_taken/_target  : PC redirect (wins over pc_stall)
//   if_instr, if_valid    : fetch data
//   *_stall, *_bubble     : hazard-unit controls
//   id_*                  : decoded fields and register-file data
//   forward_rs*, *_result : forwarding selects and sources
//   pc, if_id_*, id_ex_*  : registered stage outputs
//   stall_count           : cycles with pc_stall, saturating
//   bubble_count          : cycles with any bubble, saturating
module pipe_stage_regs
  import rv32_pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  logic [31:0]  if_instr,
  input  logic         if_valid,
  input  logic         pc_stall,
  input  logic         if_id_stall,
  input  logic         id_ex_stall,
  input  logic         if_id_bubble,
  input  logic         id_ex_bubble,
  input  reg_addr_t    id_rd,
  input  logic         id_regwrite,
  input  logic         id_mem_read_en,
  input  logic [31:0]  id_rs1_data,
  input  logic [31:0]  id_rs2_data,
  input  forward_sel_t forward_rs1,
  input  forward_sel_t forward_rs2,
  input  logic [31:0]  ex_mem_result,
  input  logic [31:0]  wb_result,
  output logic [31:0]  pc,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_instr,
  output logic         if_id_valid,
  output logic [31:0]  id_ex_pc,
  output logic [31:0]  id_ex_rs1_data,
  output logic [31:0]  id_ex_rs2_data,
  output reg_addr_t    id_ex_rd,
  output logic         id_ex_regwrite,
  output logic         id_ex_mem_read_en,
  output logic         id_ex_valid,
  output logic [15:0]  stall_count,
  output logic [15:0]  bubble_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d, ifid_instr_q, ifid_instr_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] idex_pc_q, idex_pc_d, idex_rs1_q, idex_rs1_d, idex_rs2_q, idex_rs2_d;
  reg_addr_t   idex_rd_q, idex_rd_d;
  logic        idex_rw_q, idex_rw_d, idex_mr_q, idex_mr_d, idex_vld_q, idex_vld_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, bub_cnt_q, bub_cnt_d;
  logic [31:0] rs1_fwd, rs2_fwd;

  fwd_mux u_fwd_rs1 (
    .sel_i(forward_rs1), .rf_data_i(id_rs1_data),
    .mem_data_i(ex_mem_result), .wb_data_i(wb_result), .data_o(rs1_fwd)
  );

  fwd_mux u_fwd_rs2 (
    .sel_i(forward_rs2), .rf_data_i(id_rs2_data),
    .mem_data_i(ex_mem_result), .wb_data_i(wb_result), .data_o(rs2_fwd)
  );

  always_comb begin
    // PC: branch beats stall; 32-bit wrap is intentional.
    pc_d = pc_q + 32'd4;
    if (branch_taken)  pc_d = branch_target;
    else if (pc_stall) pc_d = pc_q;

    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_vld_d   = ifid_vld_q;
    if (if_id_bubble) begin
      ifid_pc_d    = 32'd0;
      ifid_instr_d = NOP_INSTR;
      ifid_vld_d   = 1'b0;
    end else if (!if_id_stall) begin
      ifid_pc_d    = pc_q;
      ifid_instr_d = if_valid ? if_instr : NOP_INSTR;
      ifid_vld_d   = if_valid;
    end

    idex_pc_d  = idex_pc_q;
    idex_rs1_d = idex_rs1_q;
    idex_rs2_d = idex_rs2_q;
    idex_rd_d  = idex_rd_q;
    idex_rw_d  = idex_rw_q;
    idex_mr_d  = idex_mr_q;
    idex_vld_d = idex_vld_q;
    if (id_ex_bubble) begin
      idex_pc_d  = 32'd0;
      idex_rs1_d = 32'd0;
      idex_rs2_d = 32'd0;
      idex_rd_d  = '0;
      idex_rw_d  = 1'b0;
      idex_mr_d  = 1'b0;
      idex_vld_d = 1'b0;
    end else if (!id_ex_stall) begin
      idex_pc_d  = ifid_pc_q;
      idex_rs1_d = rs1_fwd;
      idex_rs2_d = rs2_fwd;
      idex_rd_d  = id_rd;
      // An invalid slot must never write or load.
      idex_rw_d  = id_regwrite & ifid_vld_q;
      idex_mr_d  = id_mem_read_en & ifid_vld_q;
      idex_vld_d = ifid_vld_q;
    end

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    bub_cnt_d = bub_cnt_q;
    if ((if_id_bubble || id_ex_bubble) && bub_cnt_q != 16'hFFFF) bub_cnt_d = bub_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      ifid_vld_q   <= 1'b0;
      idex_pc_q    <= 32'd0;
      idex_rs1_q   <= 32'd0;
      idex_rs2_q   <= 32'd0;
      idex_rd_q    <= '0;
      idex_rw_q    <= 1'b0;
      idex_mr_q    <= 1'b0;
      idex_vld_q   <= 1'b0;
      stall_cnt_q  <= 16'd0;
      bub_cnt_q    <= 16'd0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_vld_q   <= ifid_vld_d;
      idex_pc_q    <= idex_pc_d;
      idex_rs1_q   <= idex_rs1_d;
      idex_rs2_q   <= idex_rs2_d;
      idex_rd_q    <= idex_rd_d;
      idex_rw_q    <= idex_rw_d;
      idex_mr_q    <= idex_mr_d;
      idex_vld_q   <= idex_vld_d;
      stall_cnt_q  <= stall_cnt_d;
      bub_cnt_q    <= bub_cnt_d;
    end
  end

  assign pc                = pc_q;
  assign if_id_pc          = ifid_pc_q;
  assign if_id_instr       = ifid_instr_q;
  assign if_id_valid       = ifid_vld_q;
  assign id_ex_pc          = idex_pc_q;
  assign id_ex_rs1_data    = idex_rs1_q;
  assign id_ex_rs2_data    = idex_rs2_q;
  assign id_ex_rd          = idex_rd_q;
  assign id_ex_regwrite    = idex_rw_q;
  assign id_ex_mem_read_en = idex_mr_q;
  assign id_ex_valid       = idex_vld_q;
  assign stall_count       = stall_cnt_q;
  assign bubble_count      = bub_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;
  import rv32_pipeline_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, branch_taken, if_valid, pc_stall, if_id_stall, id_ex_stall;
  logic if_id_bubble, id_ex_bubble, id_regwrite, id_mem_read_en;
  logic [31:0] branch_target, if_instr, id_rs1_data, id_rs2_data, ex_mem_result, wb_result;
  reg_addr_t id_rd;
  forward_sel_t forward_rs1, forward_rs2;

  logic [31:0] pc, if_id_pc, if_id_instr, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data;
  logic if_id_valid, id_ex_regwrite, id_ex_mem_read_en, id_ex_valid;
  reg_addr_t id_ex_rd;
  logic [15:0] stall_count, bubble_count;

  pipe_stage_regs dut (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .branch_target(branch_target),
    .if_instr(if_instr), .if_valid(if_valid), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_mem_read_en(id_mem_read_en),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .forward_rs1(forward_rs1),
    .forward_rs2(forward_rs2), .ex_mem_result(ex_mem_result), .wb_result(wb_result),
    .pc(pc), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_mem_read_en(id_ex_mem_read_en),
    .id_ex_valid(id_ex_valid), .stall_count(stall_count), .bubble_count(bubble_count)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: one record per architectural stage.
  typedef struct {
    logic [31:0] pc, instr, rs1, rs2;
    logic [4:0]  rd;
    logic        vld, rw, mr;
  } stage_t;

  logic [31:0] m_pc;
  stage_t m_ifid, m_idex;
  int m_stalls, m_bubbles;

  function automatic logic [31:0] pick(forward_sel_t s, logic [31:0] rf);
    if (s == FWD_MEM) return ex_mem_result;
    if (s == FWD_WB)  return wb_result;
    return rf;
  endfunction

  task automatic model_step();
    stage_t z;
    z = '{pc: 0, instr: 0, rs1: 0, rs2: 0, rd: 0, vld: 0, rw: 0, mr: 0};
    if (!rst_n) begin
      m_pc = 32'd0; m_ifid = z; m_ifid.instr = 32'h13; m_idex = z;
      m_stalls = 0; m_bubbles = 0;
      return;
    end
    if (id_ex_bubble) m_idex = z;
    else if (!id_ex_stall) begin
      m_idex.pc  = m_ifid.pc;
      m_idex.vld = m_ifid.vld;
      m_idex.rd  = id_rd;
      m_idex.rw  = id_regwrite && m_ifid.vld;
      m_idex.mr  = id_mem_read_en && m_ifid.vld;
      m_idex.rs1 = pick(forward_rs1, id_rs1_data);
      m_idex.rs2 = pick(forward_rs2, id_rs2_data);
    end
    if (if_id_bubble) begin m_ifid = z; m_ifid.instr = 32'h13; end
    else if (!if_id_stall) begin
      m_ifid.pc = m_pc; m_ifid.vld = if_valid;
      m_ifid.instr = if_valid ? if_instr : 32'h13;
    end
    if (branch_taken) m_pc = branch_target;
    else if (!pc_stall) m_pc = m_pc + 32'd4;
    if (pc_stall) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
    if (if_id_bubble || id_ex_bubble) m_bubbles = (m_bubbles < 65535) ? m_bubbles + 1 : 65535;
  endtask

  task automatic check_all();
    chk("pc", pc, m_pc);
    chk("if_id_pc", if_id_pc, m_ifid.pc);
    chk("if_id_instr", if_id_instr, m_ifid.instr);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_ifid.vld});
    chk("id_ex_pc", id_ex_pc, m_idex.pc);
    chk("id_ex_rs1", id_ex_rs1_data, m_idex.rs1);
    chk("id_ex_rs2", id_ex_rs2_data, m_idex.rs2);
    chk("id_ex_rd", {27'd0, id_ex_rd}, {27'd0, m_idex.rd});
    chk("id_ex_ctl", {29'd0, id_ex_regwrite, id_ex_mem_read_en, id_ex_valid},
        {29'd0, m_idex.rw, m_idex.mr, m_idex.vld});
    chk("stall_count", {16'd0, stall_count}, m_stalls[31:0]);
    chk("bubble_count", {16'd0, bubble_count}, m_bubbles[31:0]);
  endtask

  // Inputs change on negedge; model and DUT both sample at posedge.
  task automatic tick(input bit full = 1);
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (full) check_all();
  endtask

  task automatic quiet();
    branch_taken = 0; pc_stall = 0; if_id_stall = 0; id_ex_stall = 0;
    if_id_bubble = 0; id_ex_bubble = 0; forward_rs1 = FWD_NONE; forward_rs2 = FWD_NONE;
  endtask

  task automatic rand_data();
    if_instr = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
    ex_mem_result = $urandom; wb_result = $urandom; branch_target = $urandom & 32'hFFFF_FFFC;
    id_rd = reg_addr_t'($urandom_range(0, 31));
    id_regwrite = $urandom_range(0, 1) == 1; id_mem_read_en = $urandom_range(0, 1) == 1;
  endtask

  task automatic rand_ctl();
    branch_taken = $urandom_range(0, 7) == 0;
    pc_stall     = $urandom_range(0, 4) == 0;
    if_id_stall  = $urandom_range(0, 4) == 0;
    id_ex_stall  = $urandom_range(0, 5) == 0;
    if_id_bubble = $urandom_range(0, 6) == 0;
    id_ex_bubble = $urandom_range(0, 5) == 0;
    if_valid     = $urandom_range(0, 3) != 0;
    forward_rs1  = forward_sel_t'($urandom_range(0, 3));
    forward_rs2  = forward_sel_t'($urandom_range(0, 3));
  endtask

  initial begin
    quiet(); rand_data(); if_valid = 1; rst_n = 0;
    // Reset must override hazard inputs.
    branch_taken = 1; pc_stall = 1; if_id_bubble = 1;
    @(negedge clk);
    tick();
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", if_id_instr, 32'h13);
    quiet(); rst_n = 1; if_valid = 1;

    // Straight-line fetch: pc 0,4,8,12 with stage PCs lagging.
    rand_data(); tick(); chk("seq_pc4", pc, 32'd4); chk("seq_ifid0", if_id_pc, 32'd0);
    rand_data(); tick(); chk("seq_pc8", pc, 32'd8);

    // Load-use style hazard at pc=8.
    rand_data(); id_regwrite = 1;
    pc_stall = 1; if_id_stall = 1; id_ex_bubble = 1;
    tick();
    chk("haz_pc", pc, 32'd8);
    chk("haz_ifid", if_id_pc, 32'd4);
    chk("haz_idex", {30'd0, id_ex_valid, id_ex_regwrite}, 32'd0);
    chk("haz_cnt", {stall_count, bubble_count}, {16'd1, 16'd1});
    quiet(); rand_data(); tick(); chk("seq_pc12", pc, 32'd12);

    // Branch beats stall; IF/ID flushed.
    branch_target = 32'h100; branch_taken = 1; pc_stall = 1; if_id_bubble = 1;
    tick();
    chk("br_pc", pc, 32'h100);
    chk("br_ifid", {if_id_instr[30:0], if_id_valid}, {31'h13, 1'b0});
    quiet(); rand_data(); tick();

    // Forwarding both operands.
    forward_rs1 = FWD_MEM; ex_mem_result = 32'hDEADBEEF;
    forward_rs2 = FWD_WB;  wb_result = 32'h12345678;
    tick();
    chk("fwd_rs1", id_ex_rs1_data, 32'hDEADBEEF);
    chk("fwd_rs2", id_ex_rs2_data, 32'h12345678);
    forward_rs1 = forward_sel_t'(2'd3); id_rs1_data = 32'hA5A5_0001;
    tick();
    chk("fwd_rsv", id_ex_rs1_data, 32'hA5A5_0001);

    // PC wrap.
    quiet(); branch_target = 32'hFFFF_FFFC; branch_taken = 1; tick();
    branch_taken = 0; tick(); chk("wrap", pc, 32'd0);

    // Random traffic with occasional mid-stall resets.
    for (int i = 0; i < 3000; i++) begin
      rand_data(); rand_ctl();
      rst_n = $urandom_range(0, 99) != 0;
      tick();
    end
    rst_n = 1; quiet();

    // Counter saturation, then reset.
    pc_stall = 1;
    for (int i = 0; i < 70000; i++) tick(0);
    check_all();
    chk("sat", {16'd0, stall_count}, 32'hFFFF);
    rst_n = 0; branch_taken = 1; id_ex_bubble = 1;
    tick();
    chk("post_rst_cnt", {stall_count, bubble_count}, 32'd0);
    quiet(); rst_n = 1; tick(); chk("post_rst_pc", pc, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
